uart_frame_parser: RTL and testbench
====================================

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 2000, inter-byte timeout in CLK cycles.
REQ-004 SHALL have port CLK  input  1  system clock; one clock; all logic on posedge CLK.
REQ-005 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port RX_DATA  input  8  received byte from the UART receiver.
REQ-007 SHALL have port RX_EN  input  1  one-cycle strobe; RX_DATA valid this cycle.
REQ-008 SHALL have port FRAME_VALID  output  1  level; a complete, checked frame is held.
REQ-009 SHALL have port FRAME_ACK  input  1  consumer releases the held frame.
REQ-010 SHALL have port FRAME_CMD  output  8  command byte of the held frame.
REQ-011 SHALL have port FRAME_LEN  output  8  payload length of the held frame.
REQ-012 SHALL have port RD_ADDR  input  clog2(MAX_LEN)  payload read index.
REQ-013 SHALL have port RD_DATA  output  8  payload byte; registered, 1-cycle read latency.
REQ-014 SHALL have port ERROR  output  1  one-cycle pulse on any frame error or overrun.
REQ-015 SHALL have port ERR_CODE  output  2  cause of the last ERROR; held until the next ERROR.

Function
REQ-016 Frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, CHK; no escaping; SYNC_BYTE inside a frame is data.
REQ-017 CHK SHALL equal (CMD + LEN + sum of payload) mod 256.
REQ-018 States SHALL be ST_HUNT, ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK, ST_HOLD.
REQ-019 ST_HUNT: RX_EN with RX_DATA==SYNC_BYTE -> ST_CMD; any other byte is discarded silently.
REQ-020 ST_CMD: on RX_EN, capture CMD, initialise sum to CMD -> ST_LEN.
REQ-021 ST_LEN: on RX_EN, LEN>MAX_LEN -> ERROR, ERR_CODE=1, ST_HUNT; LEN==0 -> ST_CHECK; otherwise -> ST_PAYLOAD with index 0.
REQ-022 ST_PAYLOAD: each RX_EN writes the byte to payload buffer[index], adds it to the sum, and increments index; the byte at index LEN-1 -> ST_CHECK.
REQ-023 ST_CHECK: on RX_EN, a match -> ST_HOLD with FRAME_VALID=1 from the next cycle; a mismatch -> ERROR, ERR_CODE=2, ST_HUNT.
REQ-024 Timeout counter SHALL clear on every RX_EN and on state entry, and SHALL count only in ST_CMD..ST_CHECK; reaching TIMEOUT -> ERROR, ERR_CODE=3, ST_HUNT.
REQ-025 ST_HOLD: FRAME_VALID, FRAME_CMD, FRAME_LEN and buffer contents SHALL be stable until FRAME_ACK.
REQ-026 FRAME_ACK in ST_HOLD -> ST_HUNT; FRAME_VALID SHALL fall the next cycle; FRAME_ACK outside ST_HOLD is ignored.
REQ-027 RX_EN in ST_HOLD, including the FRAME_ACK cycle, SHALL discard the byte and pulse ERROR with ERR_CODE=0 (overrun).
REQ-028 RD_DATA SHALL equal buffer[RD_ADDR] of the previous cycle in every state; indices >= FRAME_LEN return stale data.
REQ-029 Sum SHALL be 8 bits wrapping; index SHALL be 8 bits and never exceed MAX_LEN-1.
REQ-030 An error SHALL leave FRAME_CMD, FRAME_LEN and FRAME_VALID unchanged, with FRAME_VALID=0 outside ST_HOLD.

Reset
REQ-031 RESET SHALL asynchronously force ST_HUNT, FRAME_VALID=0, ERROR=0, ERR_CODE=0, FRAME_CMD=0, FRAME_LEN=0, RD_DATA=0, and clear the sum, index and timeout counter; buffer contents are undefined.
REQ-032 RESET mid-frame SHALL abandon the frame without an ERROR pulse; the first accepted byte after release is a SYNC_BYTE in ST_HUNT.

Verification
REQ-033 Bytes AA 01 02 10 20 33 -> FRAME_VALID=1, CMD=01, LEN=02, RD_DATA(0)=10, RD_DATA(1)=20, no ERROR; FRAME_ACK -> FRAME_VALID=0 next cycle.
REQ-034 Bytes 55 AA 05 00 05 -> 55 ignored; FRAME_VALID=1, CMD=05, LEN=00; bytes AA 01 01 7F 00 -> ERROR, ERR_CODE=2, FRAME_VALID stays 0.
REQ-035 Bytes AA 03 11 -> ERROR, ERR_CODE=1; a following AA 02 01 AA AD is accepted with payload byte AA.
REQ-036 Bytes AA 01 then no RX_EN for TIMEOUT cycles -> ERROR, ERR_CODE=3, return to ST_HUNT; the next valid frame is accepted.
REQ-037 During ST_HOLD, RX_EN with byte AA -> ERROR, ERR_CODE=0, held frame unchanged; RX_EN in the FRAME_ACK cycle is also dropped.
REQ-038 RESET asserted after AA 01 02 10, then released, then bytes 20 33 -> no FRAME_VALID, no ERROR.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: SYNC, CMD, LEN, payload, additive checksum.
// A checked frame is held in a payload buffer until the consumer acknowledges it.
module uart_frame_parser #(
   parameter logic [7:0] SYNC_BYTE = 8'hAA,
   parameter int         MAX_LEN   = 16,
   parameter int         TIMEOUT   = 2000,
   localparam int        AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [7:0]    RX_DATA,
   input  logic          RX_EN,
   output logic          FRAME_VALID,
   input  logic          FRAME_ACK,
   output logic [7:0]    FRAME_CMD,
   output logic [7:0]    FRAME_LEN,
   input  logic [AW-1:0] RD_ADDR,
   output logic [7:0]    RD_DATA,
   output logic          ERROR,
   output logic [1:0]    ERR_CODE
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {
      ST_HUNT    = 3'd0,
      ST_CMD     = 3'd1,
      ST_LEN     = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHECK   = 3'd4,
      ST_HOLD    = 3'd5
   } state_t;

   state_t        r_state;
   logic [7:0]    r_cmd;
   logic [7:0]    r_len;
   logic [7:0]    r_sum;
   logic [7:0]    r_idx;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_frame_cmd;
   logic [7:0]    r_frame_len;
   logic [7:0]    r_rd_data;
   logic          r_valid;
   logic          r_error;
   logic [1:0]    r_err_code;
   logic [7:0]    r_buf [2**AW];

   logic          w_buf_we;
   logic [AW-1:0] w_wr_addr;
   logic          w_tmo_hit;
   logic [7:0]    w_sum_next;

   assign w_buf_we   = (r_state == ST_PAYLOAD) && RX_EN;
   assign w_wr_addr  = r_idx[AW-1:0];
   assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT - 1));
   assign w_sum_next = r_sum + RX_DATA;

   // Payload storage has no reset; only written while collecting payload bytes.
   always_ff @(posedge CLK) begin
      if (w_buf_we) begin
         r_buf[w_wr_addr] <= RX_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state     <= ST_HUNT;
         r_cmd       <= 8'h00;
         r_len       <= 8'h00;
         r_sum       <= 8'h00;
         r_idx       <= 8'h00;
         r_tmo       <= {TW{1'b0}};
         r_frame_cmd <= 8'h00;
         r_frame_len <= 8'h00;
         r_rd_data   <= 8'h00;
         r_valid     <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         r_error   <= 1'b0;
         r_rd_data <= r_buf[RD_ADDR];
         case (r_state)
            ST_HUNT: begin
               r_valid <= 1'b0;
               r_tmo   <= {TW{1'b0}};
               if (RX_EN && (RX_DATA == SYNC_BYTE)) begin
                  r_state <= ST_CMD;
               end
            end
            ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK: begin
               if (RX_EN) begin
                  r_tmo <= {TW{1'b0}};
                  case (r_state)
                     ST_CMD: begin
                        r_cmd   <= RX_DATA;
                        r_sum   <= RX_DATA;
                        r_state <= ST_LEN;
                     end
                     ST_LEN: begin
                        r_len <= RX_DATA;
                        r_sum <= w_sum_next;
                        r_idx <= 8'h00;
                        if (RX_DATA > 8'(MAX_LEN)) begin
                           r_error    <= 1'b1;
                           r_err_code <= 2'd1;
                           r_state    <= ST_HUNT;
                        end else if (RX_DATA == 8'h00) begin
                           r_state <= ST_CHECK;
                        end else begin
                           r_state <= ST_PAYLOAD;
                        end
                     end
                     ST_PAYLOAD: begin
                        r_sum <= w_sum_next;
                        // Index stops at the last byte so it never passes MAX_LEN-1.
                        if (r_idx == (r_len - 8'd1)) begin
                           r_state <= ST_CHECK;
                        end else begin
                           r_idx <= r_idx + 8'd1;
                        end
                     end
                     ST_CHECK: begin
                        if (RX_DATA == r_sum) begin
                           r_frame_cmd <= r_cmd;
                           r_frame_len <= r_len;
                           r_valid     <= 1'b1;
                           r_state     <= ST_HOLD;
                        end else begin
                           r_error    <= 1'b1;
                           r_err_code <= 2'd2;
                           r_state    <= ST_HUNT;
                        end
                     end
                     default: r_state <= ST_HUNT;
                  endcase
               end else if (w_tmo_hit) begin
                  r_tmo      <= {TW{1'b0}};
                  r_error    <= 1'b1;
                  r_err_code <= 2'd3;
                  r_state    <= ST_HUNT;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            ST_HOLD: begin
               // A byte arriving while a frame is held is an overrun, even on the ack cycle.
               if (RX_EN) begin
                  r_error    <= 1'b1;
                  r_err_code <= 2'd0;
               end
               if (FRAME_ACK) begin
                  r_valid <= 1'b0;
                  r_state <= ST_HUNT;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_state <= ST_HUNT;
            end
         endcase
      end
   end

   assign FRAME_VALID = r_valid;
   assign FRAME_CMD   = r_frame_cmd;
   assign FRAME_LEN   = r_frame_len;
   assign RD_DATA     = r_rd_data;
   assign ERROR       = r_error;
   assign ERR_CODE    = r_err_code;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with hand-computed expectations.
module tb_uart_frame_parser;

   localparam int TMO = 40;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] RX_DATA = 8'h00;
   logic       RX_EN = 1'b0;
   logic       FRAME_VALID;
   logic       FRAME_ACK = 1'b0;
   logic [7:0] FRAME_CMD;
   logic [7:0] FRAME_LEN;
   logic [3:0] RD_ADDR = 4'd0;
   logic [7:0] RD_DATA;
   logic       ERROR;
   logic [1:0] ERR_CODE;

   int vectors = 0;
   int miscompares = 0;
   int err_count = 0;
   int base;
   int n;

   uart_frame_parser #(.SYNC_BYTE(8'hAA), .MAX_LEN(16), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_EN(RX_EN),
      .FRAME_VALID(FRAME_VALID), .FRAME_ACK(FRAME_ACK), .FRAME_CMD(FRAME_CMD),
      .FRAME_LEN(FRAME_LEN), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
      .ERROR(ERROR), .ERR_CODE(ERR_CODE)
   );

   always #5 CLK = ~CLK;

   // ERROR is a one-cycle pulse; count each pulse once, mid-cycle.
   always @(negedge CLK) if (ERROR === 1'b1) err_count++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      RX_DATA = b;
      RX_EN   = 1'b1;
      @(posedge CLK);
      #1;
      RX_EN   = 1'b0;
   endtask

   task automatic ack();
      FRAME_ACK = 1'b1;
      @(posedge CLK);
      #1;
      FRAME_ACK = 1'b0;
   endtask

   task automatic read(input logic [3:0] a, input logic [7:0] exp, input string tag);
      RD_ADDR = a;
      @(posedge CLK);
      #1;
      check(tag, {8'h00, RD_DATA}, {8'h00, exp});
   endtask

   initial begin
      repeat (3) @(posedge CLK);
      #1;
      check("rst_valid", {15'd0, FRAME_VALID}, 16'd0);
      check("rst_error", {15'd0, ERROR}, 16'd0);
      check("rst_code", {14'd0, ERR_CODE}, 16'd0);
      check("rst_cmd", {8'h00, FRAME_CMD}, 16'h0000);
      check("rst_len", {8'h00, FRAME_LEN}, 16'h0000);
      check("rst_rd", {8'h00, RD_DATA}, 16'h0000);
      @(negedge CLK);
      RESET = 1'b0;
      @(posedge CLK);
      #1;

      // Basic two-byte frame
      send(8'hAA); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
      check("f1_valid", {15'd0, FRAME_VALID}, 16'd1);
      check("f1_cmd", {8'h00, FRAME_CMD}, 16'h0001);
      check("f1_len", {8'h00, FRAME_LEN}, 16'h0002);
      read(4'd0, 8'h10, "f1_rd0");
      read(4'd1, 8'h20, "f1_rd1");
      check("f1_noerr", 16'(err_count), 16'd0);
      ack();
      check("f1_ack_valid", {15'd0, FRAME_VALID}, 16'd0);

      // Leading garbage, zero-length frame, then a checksum error
      send(8'h55); send(8'hAA); send(8'h05); send(8'h00); send(8'h05);
      check("f2_valid", {15'd0, FRAME_VALID}, 16'd1);
      check("f2_cmd", {8'h00, FRAME_CMD}, 16'h0005);
      check("f2_len", {8'h00, FRAME_LEN}, 16'h0000);
      ack();
      send(8'hAA); send(8'h01); send(8'h01); send(8'h7F); send(8'h00);
      check("chk_err", {15'd0, ERROR}, 16'd1);
      check("chk_code", {14'd0, ERR_CODE}, 16'd2);
      check("chk_valid", {15'd0, FRAME_VALID}, 16'd0);
      check("chk_cmd_kept", {8'h00, FRAME_CMD}, 16'h0005);

      // Over-length, then a frame carrying the sync value as payload
      send(8'hAA); send(8'h03); send(8'h11);
      check("len_err", {15'd0, ERROR}, 16'd1);
      check("len_code", {14'd0, ERR_CODE}, 16'd1);
      send(8'hAA); send(8'h02); send(8'h01); send(8'hAA); send(8'hAD);
      check("f3_valid", {15'd0, FRAME_VALID}, 16'd1);
      check("f3_cmd", {8'h00, FRAME_CMD}, 16'h0002);
      check("f3_len", {8'h00, FRAME_LEN}, 16'h0001);
      read(4'd0, 8'hAA, "f3_rd0");
      ack();

      // Inter-byte timeout
      send(8'hAA); send(8'h01);
      n = 0;
      while (n < 3 * TMO && ERROR !== 1'b1) begin
         @(posedge CLK);
         #1;
         n++;
      end
      check("tmo_cycles", 16'(n), 16'(TMO));
      check("tmo_code", {14'd0, ERR_CODE}, 16'd3);
      send(8'hAA); send(8'h07); send(8'h01); send(8'h5A); send(8'h62);
      check("f4_valid", {15'd0, FRAME_VALID}, 16'd1);
      check("f4_cmd", {8'h00, FRAME_CMD}, 16'h0007);

      // Overrun while holding, and on the acknowledge cycle
      send(8'hAA);
      check("ovr_err", {15'd0, ERROR}, 16'd1);
      check("ovr_code", {14'd0, ERR_CODE}, 16'd0);
      check("ovr_valid", {15'd0, FRAME_VALID}, 16'd1);
      check("ovr_len", {8'h00, FRAME_LEN}, 16'h0001);
      read(4'd0, 8'h5A, "ovr_rd0");
      RX_DATA = 8'hAA; RX_EN = 1'b1; FRAME_ACK = 1'b1;
      @(posedge CLK);
      #1;
      RX_EN = 1'b0; FRAME_ACK = 1'b0;
      check("ackovr_err", {15'd0, ERROR}, 16'd1);
      check("ackovr_code", {14'd0, ERR_CODE}, 16'd0);
      check("ackovr_valid", {15'd0, FRAME_VALID}, 16'd0);
      send(8'h05); send(8'h00); send(8'h05);
      check("ackovr_dropped", {15'd0, FRAME_VALID}, 16'd0);

      // Reset mid-frame abandons it silently
      send(8'hAA); send(8'h01); send(8'h02); send(8'h10);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      base = err_count;
      send(8'h20); send(8'h33);
      repeat (2) @(posedge CLK);
      #1;
      check("rst_mid_valid", {15'd0, FRAME_VALID}, 16'd0);
      check("rst_mid_noerr", 16'(err_count - base), 16'd0);
      check("rst_mid_cmd", {8'h00, FRAME_CMD}, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
